regbank_wr_arbiter: RTL and testbench
=====================================

// Module: regbank_wr_arbiter
// PURPOSE
//   Shares one write port of an NREG x WIDTH configuration/coefficient register bank between NREQ
//   requesters (e.g. the MP3 header parser, volume control and EQ loader), using round-robin.
//   The block contains the bank itself and drives its per-register enables.
//   It also provides one combinational read port, used by the decoder datapath.
// PARAMETERS
//   NREQ   4   number of write requesters (2..8)
//   WIDTH  16  register data width
//   NREG   8   number of registers in the bank
//   AW     3   register address width; NREG <= 2**AW
// PORTS
//   clk      in   1          system clock, rising edge
//   r        in   1          asynchronous active-high reset
//   req      in   NREQ       write request per requester; level, held until ack
//   waddr    in   NREQ*AW    flattened write addresses; requester i at [i*AW +: AW]
//   wdata    in   NREQ*WIDTH flattened write data; requester i at [i*WIDTH +: WIDTH]
//   ack      out  NREQ       one-cycle pulse: requester i's write has been committed
//   hold     in   1          freeze: no new grants while high (snapshot reads by the decoder)
//   clr      in   1          synchronous clear of all bank registers
//   rd_addr  in   AW         read address
//   rd_data  out  WIDTH      bank[rd_addr], combinational; 0 if rd_addr >= NREG
//   busy     out  1          high while the FSM is in GRANT
// BEHAVIOUR
//   - Reset (r high, async):
//     - bank = 0, ack = 0, busy = 0, FSM = IDLE, priority pointer ptr = 0.
//     - Any pending request is dropped without an ack; the requester keeps req high and is re-served.
//   - FSM states: IDLE, GRANT.
//     - IDLE -> GRANT when hold=0 and |req.
//       - Grant g = first requester with req set, searching ptr, ptr+1, ... mod NREQ.
//       - Latch g, waddr[g] and wdata[g].
//     - GRANT (exactly 1 cycle):
//       - At the clock edge, write the latched data to bank[latched addr], pulse ack[g].
//       - Set ptr = (g+1) mod NREQ.
//       - Next state is IDLE.
//   - Latency: req sampled in cycle N -> bank updated and ack high in cycle N+1.
//     - rd_data shows the new value from cycle N+2.
//     - Max throughput is one write every 2 cycles.
//   - Requesters must hold waddr/wdata stable and keep req high until ack.
//     - req must drop in the cycle after ack, or a second write is issued.
//     - Dropping req before ack is illegal; the latched write still completes.
//   - Address out of range (waddr >= NREG): the write is discarded and ack is still pulsed.
//   - hold=1 in IDLE: stay in IDLE, no grants.
//     - hold=1 while already in GRANT: the write still completes (hold only blocks new grants).
//   - clr and a GRANT write in the same cycle: clr wins, all registers = 0, ack still pulsed.
//     - The requester must not assume its data survived.
//   - clr while IDLE: clears the bank only; FSM and ptr are unchanged.
//   - ack is one-hot or zero, never more than one bit set.
//   - Fairness: a continuously requesting requester is granted within NREQ grants.
// STRUCTURE
//   - Shared include regbank_defs.vh: FSM state encodings ST_IDLE/ST_GRANT.
//   - Sub-module rr_pick (combinational): inputs req and ptr -> one-hot grant plus index.
//     Implemented as a double-width mask-and-priority search.
//   - All flops use the async-reset form.
//   - The bank is a reg array with a one-hot write enable decoded from the latched address.
// TESTING
//   1. Reset then single write: req=0001, waddr0=2, wdata0=16'hBEEF.
//      -> ack=0001 exactly one cycle later; rd_addr=2 gives 16'hBEEF the next cycle.
//   2. All four requesting continuously from ptr=0:
//      -> acks in order 0,1,2,3,0, one every 2 cycles; no ack bit ever doubled.
//   3. hold=1 with req=0100 for 5 cycles -> no ack, busy=0.
//      Release hold -> ack=0100 one cycle later.
//   4. clr in the same cycle as a GRANT writing 16'h1234 to reg 5
//      -> ack pulses; reg 5 reads 0; all other registers read 0.
//   5. waddr=7 with NREG=6, wdata=16'hFFFF -> ack pulses; all registers unchanged; rd_addr=7 reads 0.
//   6. r asserted mid-GRANT (asynchronously, between edges)
//      -> ack=0, bank=0, ptr=0 immediately; a held req is served after r deasserts.

Source files
------------

// File: rtl/regbank_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// regbank_wr_arbiter_pkg
//   Shared definitions for the register-bank write arbiter:
//     ST_IDLE / ST_GRANT : FSM state encodings (1-bit, legacy-compatible)
//     ptr_w()            : width of a requester index / round-robin pointer
// ---------------------------------------------------------------------------
package regbank_wr_arbiter_pkg;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   // Index width for n requesters; never narrower than one bit.
   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/regbank_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// regbank_wr_arbiter_rr_pick
//   Combinational round-robin picker. Finds the first set request starting at
//   i_ptr and wrapping modulo NREQ.
//   Ports:
//     i_req   [NREQ-1:0]  request vector
//     i_ptr   [PW-1:0]    highest-priority requester index
//     o_valid             any request present
//     o_gnt   [NREQ-1:0]  one-hot grant (zero when o_valid is low)
//     o_idx   [PW-1:0]    index of the granted requester
// ---------------------------------------------------------------------------
module regbank_wr_arbiter_rr_pick
   import regbank_wr_arbiter_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int PW   = ptr_w(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [PW-1:0]   i_ptr,
   output logic            o_valid,
   output logic [NREQ-1:0] o_gnt,
   output logic [PW-1:0]   o_idx
);

   logic [2*NREQ-1:0] w_dbl;
   logic [2*NREQ-1:0] w_mask;
   logic [2*NREQ-1:0] w_sel;
   int                w_pos;
   int                w_idx;

   // The request vector is doubled so that a plain lowest-bit search over
   // bits >= i_ptr covers the wrap-around. The upper copy is never masked, so
   // w_sel is non-zero whenever any request is present.
   always_comb begin
      w_dbl  = {i_req, i_req};
      w_mask = ~(((2*NREQ)'(1) << i_ptr) - (2*NREQ)'(1));
      w_sel  = w_dbl & w_mask;
      w_pos  = 0;
      for (int i = 2*NREQ-1; i >= 0; i--) begin
         if (w_sel[i]) w_pos = i;
      end
      w_idx   = (w_pos >= NREQ) ? (w_pos - NREQ) : w_pos;
      o_valid = |i_req;
      o_gnt   = o_valid ? (NREQ'(1) << w_idx) : '0;
      o_idx   = o_valid ? PW'(w_idx) : '0;
   end

endmodule

// File: rtl/regbank_wr_arbiter.sv
// ---------------------------------------------------------------------------
// regbank_wr_arbiter
//   NREG x WIDTH register bank with a single round-robin arbitrated write port
//   shared by NREQ requesters, plus one combinational read port.
//   Handshake: a requester raises req[i] with waddr/wdata stable and holds it
//   until ack[i]; ack[i] is a one-cycle pulse in the cycle the write commits
//   (at the end of that cycle), and req[i] must be low in the following cycle.
//   Ports:
//     clk                    rising-edge clock
//     r                      asynchronous active-high reset
//     req     [NREQ-1:0]     per-requester write request (level)
//     waddr   [NREQ*AW-1:0]  requester i address at [i*AW +: AW]
//     wdata   [NREQ*WIDTH-1:0] requester i data at [i*WIDTH +: WIDTH]
//     ack     [NREQ-1:0]     one-hot commit pulse
//     hold                   blocks new grants (in-flight write completes)
//     clr                    synchronous clear of the whole bank
//     rd_addr [AW-1:0]       read address
//     rd_data [WIDTH-1:0]    bank[rd_addr], zero when rd_addr >= NREG
//     busy                   FSM is in GRANT (doubles as the state debug view)
// ---------------------------------------------------------------------------
module regbank_wr_arbiter
   import regbank_wr_arbiter_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 16,
   parameter int NREG  = 8,
   parameter int AW    = 3
) (
   input  logic                  clk,
   input  logic                  r,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*AW-1:0]    waddr,
   input  logic [NREQ*WIDTH-1:0] wdata,
   output logic [NREQ-1:0]       ack,
   input  logic                  hold,
   input  logic                  clr,
   input  logic [AW-1:0]         rd_addr,
   output logic [WIDTH-1:0]      rd_data,
   output logic                  busy
);

   localparam int PW = ptr_w(NREQ);

   logic [0:0]       r_state;
   logic [PW-1:0]    r_ptr;
   logic [NREQ-1:0]  r_gnt;
   logic [PW-1:0]    r_gnt_idx;
   logic [AW-1:0]    r_addr;
   logic [WIDTH-1:0] r_data;
   logic [WIDTH-1:0] r_bank [NREG];

   logic             w_pick_valid;
   logic [NREQ-1:0]  w_pick_gnt;
   logic [PW-1:0]    w_pick_idx;
   logic             w_start;
   logic [AW-1:0]    w_sel_addr;
   logic [WIDTH-1:0] w_sel_data;
   logic [PW-1:0]    w_ptr_next;
   logic [NREG-1:0]  w_we;

   regbank_wr_arbiter_rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_pick (
      .i_req   (req),
      .i_ptr   (r_ptr),
      .o_valid (w_pick_valid),
      .o_gnt   (w_pick_gnt),
      .o_idx   (w_pick_idx)
   );

   assign w_start = (r_state == ST_IDLE) && !hold && w_pick_valid;

   // Address/data of the picked requester, captured into r_addr/r_data.
   always_comb begin
      w_sel_addr = '0;
      w_sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_pick_idx == PW'(i)) begin
            w_sel_addr = waddr[i*AW +: AW];
            w_sel_data = wdata[i*WIDTH +: WIDTH];
         end
      end
   end

   assign w_ptr_next = (r_gnt_idx == PW'(NREQ-1)) ? '0 : (r_gnt_idx + PW'(1));

   always_ff @(posedge clk or posedge r) begin
      if (r) begin
         r_state   <= ST_IDLE;
         r_ptr     <= '0;
         r_gnt     <= '0;
         r_gnt_idx <= '0;
         r_addr    <= '0;
         r_data    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_state   <= ST_GRANT;
                  r_gnt     <= w_pick_gnt;
                  r_gnt_idx <= w_pick_idx;
                  r_addr    <= w_sel_addr;
                  r_data    <= w_sel_data;
               end
            end
            default: begin
               // GRANT always lasts exactly one cycle; hold is ignored here.
               r_state <= ST_IDLE;
               r_ptr   <= w_ptr_next;
            end
         endcase
      end
   end

   // One-hot register enable; an out-of-range address matches no register,
   // so the write is silently dropped while ack still pulses.
   always_comb begin
      for (int k = 0; k < NREG; k++) begin
         w_we[k] = (r_state == ST_GRANT) && (r_addr == AW'(k));
      end
   end

   // clr takes priority over a same-cycle write.
   always_ff @(posedge clk or posedge r) begin
      if (r) begin
         for (int k = 0; k < NREG; k++) r_bank[k] <= '0;
      end else if (clr) begin
         for (int k = 0; k < NREG; k++) r_bank[k] <= '0;
      end else begin
         for (int k = 0; k < NREG; k++) begin
            if (w_we[k]) r_bank[k] <= r_data;
         end
      end
   end

   always_comb begin
      rd_data = '0;
      for (int k = 0; k < NREG; k++) begin
         if (rd_addr == AW'(k)) rd_data = r_bank[k];
      end
   end

   assign busy = (r_state == ST_GRANT);
   assign ack  = busy ? r_gnt : '0;

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regbank_wr_arbiter
//   Self-checking bench for regbank_wr_arbiter (NREQ=4, WIDTH=16, NREG=6,
//   AW=3 so that addresses 6 and 7 are out of range). Inputs are driven and
//   outputs sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_regbank_wr_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 16;
   localparam int NREG  = 6;
   localparam int AW    = 3;

   logic                  clk;
   logic                  r;
   logic [NREQ-1:0]       req;
   logic [NREQ*AW-1:0]    waddr;
   logic [NREQ*WIDTH-1:0] wdata;
   logic [NREQ-1:0]       ack;
   logic                  hold;
   logic                  clr;
   logic [AW-1:0]         rd_addr;
   logic [WIDTH-1:0]      rd_data;
   logic                  busy;

   regbank_wr_arbiter #(
      .NREQ  (NREQ),
      .WIDTH (WIDTH),
      .NREG  (NREG),
      .AW    (AW)
   ) dut (
      .clk     (clk),
      .r       (r),
      .req     (req),
      .waddr   (waddr),
      .wdata   (wdata),
      .ack     (ack),
      .hold    (hold),
      .clr     (clr),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .busy    (busy)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- scoreboard state ----------------
   int                n_checks;
   int                n_errors;
   logic [WIDTH-1:0]  m_bank [8];
   int                m_ptr;
   logic [NREQ-1:0]   exp_q [$];

   typedef struct {
      int               idx;
      logic [AW-1:0]    addr;
      logic [WIDTH-1:0] data;
      logic [WIDTH-1:0] exp_rd;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      req[i]                = 1'b1;
      waddr[i*AW +: AW]     = a;
      wdata[i*WIDTH +: WIDTH] = d;
   endtask

   task automatic clear_model();
      for (int k = 0; k < 8; k++) m_bank[k] = '0;
   endtask

   task automatic do_reset();
      r     = 1'b1;
      req   = '0;
      hold  = 1'b0;
      clr   = 1'b0;
      tick();
      tick();
      r = 1'b0;
      clear_model();
      m_ptr = 0;
   endtask

   // Reads every address (including out-of-range ones); takes 8 ns.
   task automatic check_regs(input string name);
      for (int k = 0; k < 8; k++) begin
         rd_addr = AW'(k);
         #1;
         check(name, rd_data, (k < NREG) ? m_bank[k] : '0);
      end
   endtask

   // First requesting index at or after p, wrapping modulo NREQ.
   function automatic int pick(input logic [NREQ-1:0] v, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      logic             m_busy;
      logic             nb;
      logic             last_clr;
      logic             pw_valid;
      logic [AW-1:0]    pw_addr;
      logic [WIDTH-1:0] pw_data;
      logic [NREQ-1:0]  exp_ack;
      int               g;

      n_checks = 0;
      n_errors = 0;
      req = '0; waddr = '0; wdata = '0; hold = 1'b0; clr = 1'b0; rd_addr = '0;
      r = 1'b0;

      vecs[0] = '{0, 3'd2, 16'hBEEF, 16'hBEEF};
      vecs[1] = '{1, 3'd5, 16'h1234, 16'h1234};
      vecs[2] = '{3, 3'd0, 16'hFFFF, 16'hFFFF};
      vecs[3] = '{2, 3'd7, 16'hFFFF, 16'h0000};
      vecs[4] = '{1, 3'd6, 16'h5555, 16'h0000};
      vecs[5] = '{2, 3'd5, 16'h0001, 16'h0001};

      // reset state
      do_reset();
      check("rst_ack", ack, '0);
      check("rst_busy", busy, 1'b0);
      check_regs("rst_bank");

      // single writes from the table
      for (int v = 0; v < 6; v++) begin
         tick();
         set_req(vecs[v].idx, vecs[v].addr, vecs[v].data);
         check("tbl_ack_pre", ack, '0);
         tick();
         check("tbl_ack", ack, 32'(1) << vecs[v].idx);
         check("tbl_busy", busy, 1'b1);
         req = '0;
         if (int'(vecs[v].addr) < NREG) m_bank[vecs[v].addr] = vecs[v].data;
         rd_addr = vecs[v].addr;
         tick();
         check("tbl_rd", rd_data, vecs[v].exp_rd);
         check("tbl_ack_post", ack, '0);
         if (int'(vecs[v].addr) >= NREG) check_regs("tbl_oor_bank");
      end

      // all four requesting from ptr=0: acks 0,1,2,3,0 every other cycle
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, AW'(i), WIDTH'(16'h1000 + i));
      for (int c = 0; c < 9; c++) exp_q.push_back((c % 2 == 0) ? NREQ'(1 << ((c / 2) % NREQ)) : '0);
      for (int c = 0; c < 9; c++) begin
         tick();
         check("rr_ack", ack, exp_q.pop_front());
      end
      req = '0;
      for (int i = 0; i < NREQ; i++) m_bank[i] = WIDTH'(16'h1000 + i);
      tick();
      check("rr_idle", ack, '0);
      check_regs("rr_bank");

      // hold blocks new grants
      tick();
      set_req(2, 3'd4, 16'h4444);
      hold = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         check("hold_ack", ack, '0);
         check("hold_busy", busy, 1'b0);
      end
      hold = 1'b0;
      tick();
      check("hold_rel_ack", ack, 4'b0100);
      req = '0;
      m_bank[4] = 16'h4444;
      tick();
      rd_addr = 3'd4;
      #1;
      check("hold_rel_rd", rd_data, 16'h4444);

      // hold raised during GRANT does not cancel the write
      tick();
      set_req(3, 3'd1, 16'h7777);
      tick();
      check("hold_grant_ack", ack, 4'b1000);
      hold = 1'b1;
      req = '0;
      tick();
      hold = 1'b0;
      rd_addr = 3'd1;
      #1;
      check("hold_grant_rd", rd_data, 16'h7777);
      m_bank[1] = 16'h7777;

      // clr in the same cycle as a GRANT
      set_req(1, 3'd5, 16'h1234);
      tick();
      check("clr_ack", ack, 4'b0010);
      clr = 1'b1;
      req = '0;
      tick();
      clr = 1'b0;
      clear_model();
      check_regs("clr_bank");

      // async reset mid-GRANT; ptr is 2 here
      tick();
      set_req(2, 3'd0, 16'h5A5A);
      tick();
      check("pre_rst_ack", ack, 4'b0100);
      req = '0;
      tick();
      set_req(1, 3'd3, 16'hABCD);
      tick();
      check("mid_grant_ack", ack, 4'b0010);
      #2;
      r = 1'b1;
      #1;
      check("async_rst_ack", ack, '0);
      check("async_rst_busy", busy, 1'b0);
      rd_addr = 3'd0;
      #1;
      check("async_rst_bank", rd_data, '0);
      @(posedge clk);
      #1;
      r = 1'b0;
      clear_model();
      set_req(3, 3'd2, 16'h3333);
      tick();
      check("post_rst_ptr0", ack, 4'b0010);
      req[1] = 1'b0;
      m_bank[3] = 16'hABCD;
      tick();
      check("post_rst_idle", ack, '0);
      tick();
      check("post_rst_ack3", ack, 4'b1000);
      req = '0;
      m_bank[2] = 16'h3333;
      tick();
      check_regs("post_rst_bank");

      // randomized traffic against the reference model
      do_reset();
      m_busy   = 1'b0;
      last_clr = 1'b0;
      pw_valid = 1'b0;
      pw_addr  = '0;
      pw_data  = '0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         tick();
         if (pw_valid && int'(pw_addr) < NREG) m_bank[pw_addr] = pw_data;
         pw_valid = 1'b0;
         if (last_clr) clear_model();
         // req/hold still show what was sampled at the edge just passed
         exp_ack = '0;
         nb      = 1'b0;
         if (!m_busy && !hold && req != '0) begin
            g        = pick(req, m_ptr);
            exp_ack  = NREQ'(1 << g);
            nb       = 1'b1;
            pw_valid = 1'b1;
            pw_addr  = waddr[g*AW +: AW];
            pw_data  = wdata[g*WIDTH +: WIDTH];
            m_ptr    = (g + 1) % NREQ;
         end
         m_busy = nb;
         check("rnd_ack", ack, exp_ack);
         check("rnd_busy", busy, nb);
         check("rnd_rd", rd_data, (int'(rd_addr) < NREG) ? m_bank[rd_addr] : '0);
         clr      = ($urandom_range(0, 31) == 0);
         last_clr = clr;
         hold     = ($urandom_range(0, 6) == 0);
         for (int i = 0; i < NREQ; i++) begin
            if (exp_ack[i]) req[i] = 1'b0;
            else if (!req[i] && $urandom_range(0, 3) == 0)
               set_req(i, AW'($urandom_range(0, 7)), WIDTH'($urandom));
         end
         rd_addr = AW'($urandom_range(0, 7));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
